present_ctrl: RTL and testbench

Sequencing controller for the PRESENT-80 block cipher core. Accepts a key/IV configuration and a stream of 64-bit blocks over valid/ready handshakes. Drives the core through reset, key generation and the round phase, and returns one result block per input block. Supports ECB and CBC chaining in both directions, and sits between the system bus adapter and the `present` instance in the crypto subsystem.

---
 rtl/present_ctrl.sv | 125 ++++++++++++
 tb/tb_present_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_ctrl.sv
// Sequencing controller for a PRESENT-80 core: restarts the core for every
// block, waits out key generation and the round phase, and applies ECB/CBC chaining.
module present_ctrl #(
  parameter int ROUND_CYCLES = 32,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [79:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_cbc,
  input  logic             cfg_enc_dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_block,
  output logic             busy,
  output logic [CNT_W-1:0] block_count,
  output logic             core_rst,
  output logic             core_enc_dec,
  output logic [79:0]      core_key,
  output logic [63:0]      core_block_i,
  input  logic             core_end_key_gen,
  input  logic [63:0]      core_block_o
);

  // state  | meaning
  // IDLE   | accepts configuration or an input block; core held in reset
  // LOAD   | one extra cycle of core reset with the new block presented
  // KEYGEN | waiting for the core to finish key generation
  // ROUNDS | counting round cycles until the core output is valid
  // OUTPUT | result held until consumed
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] KEYGEN = 3'd2;
  localparam logic [2:0] ROUNDS = 3'd3;
  localparam logic [2:0] OUTPUT = 3'd4;

  logic [2:0]       state;
  logic [79:0]      key_r;
  logic [63:0]      chain_r;
  logic             cbc_r;
  logic             dir_r;
  logic [63:0]      blk_r;
  logic [63:0]      save_r;
  logic [63:0]      out_r;
  logic [7:0]       cnt;
  logic             out_valid_r;
  logic [CNT_W-1:0] count_r;

  // Configuration wins over an input block offered in the same cycle.
  assign cfg_ready    = (state == IDLE);
  assign in_ready     = (state == IDLE) && !cfg_valid;
  assign busy         = (state != IDLE);
  assign core_rst     = (state == IDLE) || (state == LOAD);
  assign core_key     = key_r;
  assign core_enc_dec = dir_r;
  assign core_block_i = blk_r;
  assign out_valid    = out_valid_r;
  assign out_block    = out_r;
  assign block_count  = count_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_r       <= '0;
      chain_r     <= '0;
      cbc_r       <= 1'b0;
      dir_r       <= 1'b0;
      blk_r       <= '0;
      save_r      <= '0;
      out_r       <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      count_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            key_r   <= cfg_key;
            chain_r <= cfg_iv;
            cbc_r   <= cfg_cbc;
            dir_r   <= cfg_enc_dec;
            count_r <= '0;
          end else if (in_valid) begin
            save_r <= in_block;
            blk_r  <= (cbc_r && !dir_r) ? (in_block ^ chain_r) : in_block;
            state  <= LOAD;
          end
        end
        LOAD: state <= KEYGEN;
        KEYGEN: begin
          if (core_end_key_gen) begin
            cnt   <= 8'(ROUND_CYCLES - 1);
            state <= ROUNDS;
          end
        end
        ROUNDS: begin
          if (cnt == 8'd0) begin
            out_r <= (cbc_r && dir_r) ? (core_block_o ^ chain_r) : core_block_o;
            // decryption chains on the received ciphertext, not on the result
            if (cbc_r) chain_r <= dir_r ? save_r : core_block_o;
            out_valid_r <= 1'b1;
            state       <= OUTPUT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            count_r     <= count_r + CNT_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Bench for present_ctrl: behavioural PRESENT-80 core model, vector table,
// result scoreboard and hand-written corner-case sequences.
module tb_present_ctrl;
  localparam int RC       = 16;
  localparam int CW       = 32;
  localparam int KG_DELAY = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_cbc, cfg_enc_dec;
  logic [79:0]   cfg_key;
  logic [63:0]   cfg_iv;
  logic          in_valid, in_ready;
  logic [63:0]   in_block;
  logic          out_valid, out_ready;
  logic [63:0]   out_block;
  logic          busy;
  logic [CW-1:0] block_count;
  logic          core_rst, core_enc_dec, core_end_key_gen;
  logic [79:0]   core_key;
  logic [63:0]   core_block_i, core_block_o;

  present_ctrl #(.ROUND_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_cbc(cfg_cbc), .cfg_enc_dec(cfg_enc_dec),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .block_count(block_count),
    .core_rst(core_rst), .core_enc_dec(core_enc_dec), .core_key(core_key),
    .core_block_i(core_block_i), .core_end_key_gen(core_end_key_gen),
    .core_block_o(core_block_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  int          hold = 0;
  int          rc = 0;
  int          kg = 0;
  int          stab_err = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference PRESENT-80
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbi(input logic [3:0] x);
    for (int v = 0; v < 16; v++) if (sb(4'(v)) == x) return 4'(v);
    return 4'h0;
  endfunction

  function automatic logic [63:0] present_ref(input logic [79:0] key, input logic [63:0] blk,
                                              input logic dec);
    logic [63:0] rk[33];
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    rk[1] = k[79:16];
    for (int i = 1; i <= 31; i++) begin
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
      rk[i+1] = k[79:16];
    end
    s = blk;
    if (!dec) begin
      for (int i = 1; i <= 31; i++) begin
        s = s ^ rk[i];
        for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
        t = '0;
        for (int b = 0; b < 63; b++) t[(b*16) % 63] = s[b];
        t[63] = s[63];
        s = t;
      end
      s = s ^ rk[32];
    end else begin
      s = s ^ rk[32];
      for (int i = 31; i >= 1; i--) begin
        t = '0;
        for (int b = 0; b < 63; b++) t[b] = s[(b*16) % 63];
        t[63] = s[63];
        s = t;
        for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbi(s[n*4 +: 4]);
        s = s ^ rk[i];
      end
    end
    return s;
  endfunction

  // Core model plus output-side scoreboard, acting 1 time unit after each rising edge
  initial begin : core_model
    logic        running, seen_valid;
    logic [79:0] lk;
    logic [63:0] lb, held;
    logic        ld;
    running = 1'b0; seen_valid = 1'b0;
    lk = '0; lb = '0; ld = 1'b0; held = '0;
    core_end_key_gen = 1'b0;
    core_block_o = 64'hA5A5_5A5A_DEAD_BEEF;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          held = out_block;
          check64("latency_round_cycles", 64'(rc), 64'(RC));
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
          check64("bp_out_block_stable", out_block, held);
          check64("bp_in_ready_low", 64'(in_ready), 64'd0);
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() == 0) check64("unexpected_result", out_block, 64'hFFFF_FFFF_FFFF_FFFF ^ out_block);
          else check64("out_block", out_block, exp_q.pop_front());
        end
      end else begin
        out_ready = 1'b0;
        seen_valid = 1'b0;
      end

      if (core_rst) begin
        kg = 0; rc = 0; running = 1'b0;
        core_end_key_gen = 1'b0;
        core_block_o = 64'hA5A5_5A5A_DEAD_BEEF;
      end else begin
        if (!running) begin
          running = 1'b1;
          lk = core_key; lb = core_block_i; ld = core_enc_dec;
        end else if (core_key !== lk || core_block_i !== lb || core_enc_dec !== ld) begin
          stab_err++;
        end
        if (!core_end_key_gen) begin
          kg++;
          if (kg >= KG_DELAY) core_end_key_gen = 1'b1;
        end else begin
          if (rc < 1000) rc++;
          if (rc == RC) core_block_o = present_ref(lk, lb, ld);
          else if (rc < RC) core_block_o = {32'(rc), 32'hBAD0_BAD0};
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cfg(input logic [79:0] k, input logic [63:0] iv, input logic cbc, input logic dir);
    int t;
    t = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_key = k; cfg_iv = iv; cfg_cbc = cbc; cfg_enc_dec = dir;
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    check64("cfg_accepted", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] blk, input logic [63:0] exp, input logic push);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_block = blk;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check64("in_accepted", 64'(in_ready), 64'd1);
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin @(negedge clk); t++; end
    check64("drained", 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  typedef struct {
    logic        do_cfg;
    logic [79:0] key;
    logic [63:0] iv;
    logic        cbc;
    logic        dir;
    logic [63:0] blk;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt[9];
  logic [63:0] p1, p2, p3, c1, c2, c3, ivc;
  logic [79:0] kones;
  logic [63:0] bones;
  int          exp_cnt;

  initial begin : stim
    kones = '1; bones = '1;
    ivc = 64'h0123_4567_89AB_CDEF;
    p1 = 64'h0011_2233_4455_6677;
    p2 = 64'h8899_AABB_CCDD_EEFF;
    p3 = 64'hDEAD_BEEF_CAFE_F00D;
    c1 = present_ref(80'd0, p1 ^ ivc, 1'b0);
    c2 = present_ref(80'd0, p2 ^ c1, 1'b0);
    c3 = present_ref(80'd0, p3 ^ c2, 1'b0);
    vt[0] = '{1'b1, 80'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'h5579_C138_7B22_8445};
    vt[1] = '{1'b1, kones, 64'd0, 1'b0, 1'b0, bones, 64'h3333_DCD3_2132_10D2};
    vt[2] = '{1'b1, kones, 64'd0, 1'b0, 1'b1, 64'h3333_DCD3_2132_10D2, bones};
    vt[3] = '{1'b1, 80'd0, ivc, 1'b1, 1'b0, p1, c1};
    vt[4] = '{1'b0, 80'd0, ivc, 1'b1, 1'b0, p2, c2};
    vt[5] = '{1'b0, 80'd0, ivc, 1'b1, 1'b0, p3, c3};
    vt[6] = '{1'b1, 80'd0, ivc, 1'b1, 1'b1, c1, p1};
    vt[7] = '{1'b0, 80'd0, ivc, 1'b1, 1'b1, c2, p2};
    vt[8] = '{1'b0, 80'd0, ivc, 1'b1, 1'b1, c3, p3};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0; cfg_enc_dec = 1'b0;
    in_valid = 1'b0; in_block = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check64("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check64("rst_in_ready", 64'(in_ready), 64'd1);
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_out_block", out_block, 64'd0);
    check64("rst_block_count", 64'(block_count), 64'd0);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_core_rst", 64'(core_rst), 64'd1);

    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (vt[i].do_cfg) begin
        do_cfg(vt[i].key, vt[i].iv, vt[i].cbc, vt[i].dir);
        exp_cnt = 0;
      end
      send(vt[i].blk, vt[i].exp, 1'b1);
      wait_done();
      exp_cnt++;
      check64($sformatf("vec%0d_block_count", i), 64'(block_count), 64'(exp_cnt));
    end

    // Backpressure: result held for 20 cycles
    do_cfg(80'd0, 64'd0, 1'b0, 1'b0);
    hold = 20;
    send(64'd0, 64'h5579_C138_7B22_8445, 1'b1);
    wait_done();
    check64("bp_hold_consumed", 64'(hold), 64'd0);
    check64("bp_block_count", 64'(block_count), 64'd1);

    // cfg and in offered together: config first, block under the new key
    @(negedge clk);
    cfg_valid = 1'b1; cfg_key = kones; cfg_iv = '0; cfg_cbc = 1'b0; cfg_enc_dec = 1'b0;
    in_valid = 1'b1; in_block = bones;
    #1;
    check64("both_in_ready_low", 64'(in_ready), 64'd0);
    check64("both_cfg_ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    check64("both_in_ready_next", 64'(in_ready), 64'd1);
    exp_q.push_back(64'h3333_DCD3_2132_10D2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    check64("both_block_count", 64'(block_count), 64'd1);

    // Reset during ROUNDS
    send(64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    begin
      int t;
      t = 0;
      while (rc < 5 && t < 200) begin @(negedge clk); t++; end
    end
    check64("mid_rounds_reached", 64'(rc >= 5), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("mrst_core_rst", 64'(core_rst), 64'd1);
    check64("mrst_out_valid", 64'(out_valid), 64'd0);
    check64("mrst_busy", 64'(busy), 64'd0);
    check64("mrst_block_count", 64'(block_count), 64'd0);
    check64("mrst_out_block", out_block, 64'd0);
    send(64'd0, 64'h5579_C138_7B22_8445, 1'b1);
    wait_done();
    check64("mrst_after_count", 64'(block_count), 64'd1);

    check64("core_inputs_stable", 64'(stab_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
